// File: rtl/pc_sequencer.sv
// Program-counter controller: holds the architectural PC, sequences instruction fetch over a
// valid/ready handshake and selects the next PC from PC+4, a redirect or the trap vector.
module pc_sequencer #(
    parameter int unsigned XLEN = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_valid,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            instr_done,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            redirect_is_jalr,
    input  logic            trap_req,
    output logic            misalign_trap,
    output logic [XLEN-1:0] epc,
    output logic            busy
);

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] PcStep = XLEN'(4);

    state_e          state;
    logic [XLEN-1:0] eff_target;
    logic            target_misaligned;
    logic            advance;

    assign pc_plus4  = pc + PcStep;
    assign imem_addr = pc;

    // JALR clears bit 0 of the computed target before the alignment check.
    always_comb begin
        eff_target        = redirect_target;
        eff_target[0]     = redirect_target[0] & ~redirect_is_jalr;
        target_misaligned = (eff_target[1:0] != 2'b00);
    end

    assign advance = instr_done && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StBoot;
            pc            <= RESET_VECTOR;
            epc           <= '0;
            imem_valid    <= 1'b0;
            misalign_trap <= 1'b0;
            busy          <= 1'b0;
        end else begin
            misalign_trap <= 1'b0;
            case (state)
                StBoot: begin
                    state      <= StFetch;
                    imem_valid <= 1'b1;
                    busy       <= 1'b1;
                end
                StFetch: begin
                    if (imem_ready) begin
                        state      <= StExec;
                        imem_valid <= 1'b0;
                    end
                end
                StExec: begin
                    if (advance) begin
                        state      <= StFetch;
                        imem_valid <= 1'b1;
                        if (trap_req) begin
                            pc  <= TRAP_VECTOR;
                            epc <= pc;
                        end else if (redirect_valid && target_misaligned) begin
                            pc            <= TRAP_VECTOR;
                            epc           <= pc;
                            misalign_trap <= 1'b1;
                        end else if (redirect_valid) begin
                            pc <= eff_target;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end
                end
                default: begin
                    state      <= StBoot;
                    imem_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues the expected next fetch, a monitor checks
// every fetch handshake against the queue; a few direct checks cover reset, stall and waits.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_done;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        redirect_is_jalr;
    logic        trap_req;
    logic        misalign_trap;
    logic [31:0] epc;
    logic        busy;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] epc;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   failed = 0;

    pc_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_valid       (imem_valid),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .instr_done       (instr_done),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .redirect_is_jalr (redirect_is_jalr),
        .trap_req         (trap_req),
        .misalign_trap    (misalign_trap),
        .epc              (epc),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] e, input logic m);
        exp_t r;
        r.addr = a;
        r.epc  = e;
        r.mis  = m;
        return r;
    endfunction

    // Monitor: each accepted fetch must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && imem_valid && imem_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("fetch_addr", imem_addr, e.addr);
                check("fetch_pc_plus4", pc_plus4, e.addr + 32'd4);
                check("fetch_epc", epc, e.epc);
                check("fetch_misalign", {31'd0, misalign_trap}, {31'd0, e.mis});
            end
        end
    end

    task automatic wait_fetch();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (imem_valid && imem_ready) seen = 1'b1;
        end
        if (!seen) check("fetch_timeout", 32'd0, 32'd1);
    endtask

    // Runs one instruction: waits for its fetch, then completes it with the given controls.
    task automatic exec_instr(input logic [31:0] cur_pc, input bit rv, input logic [31:0] tgt,
                              input bit jalr, input bit trap, input int stall_cycles,
                              input bit ready_next, input logic [31:0] exp_addr,
                              input logic [31:0] exp_epc, input bit exp_mis);
        wait_fetch();
        @(posedge clk);
        #1;
        check("exec_valid_low", {31'd0, imem_valid}, 32'd0);
        check("exec_busy", {31'd0, busy}, 32'd1);
        instr_done       = 1'b1;
        redirect_valid   = rv;
        redirect_target  = tgt;
        redirect_is_jalr = jalr;
        trap_req         = trap;
        stall            = (stall_cycles > 0);
        for (int i = 0; i < stall_cycles; i++) begin
            @(posedge clk);
            #1;
            check("stall_hold_pc", pc, cur_pc);
            check("stall_no_trap", {31'd0, misalign_trap}, 32'd0);
        end
        stall      = 1'b0;
        imem_ready = ready_next;
        exp_q.push_back(mk(exp_addr, exp_epc, exp_mis));
        @(posedge clk);
        #1;
        instr_done       = 1'b0;
        redirect_valid   = 1'b0;
        redirect_is_jalr = 1'b0;
        trap_req         = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        imem_ready       = 1'b1;
        instr_done       = 1'b0;
        stall            = 1'b0;
        redirect_valid   = 1'b0;
        redirect_target  = 32'd0;
        redirect_is_jalr = 1'b0;
        trap_req         = 1'b0;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        check("rst_valid", {31'd0, imem_valid}, 32'd0);
        check("rst_misalign", {31'd0, misalign_trap}, 32'd0);
        check("rst_epc", epc, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(mk(32'h0, 32'h0, 1'b0));

        exec_instr(32'h0, 0, 32'h0, 0, 0, 0, 1, 32'h4, 32'h0, 0);
        exec_instr(32'h4, 0, 32'h0, 0, 0, 0, 0, 32'h8, 32'h0, 0);
        // imem_ready held low for three FETCH cycles at pc=0x8.
        for (int i = 0; i < 3; i++) begin
            check("wait_valid", {31'd0, imem_valid}, 32'd1);
            check("wait_addr", imem_addr, 32'h8);
            @(posedge clk);
            #1;
        end
        check("wait_valid_last", {31'd0, imem_valid}, 32'd1);
        check("wait_addr_last", imem_addr, 32'h8);
        imem_ready = 1'b1;

        exec_instr(32'h8,        0, 32'h0,        0, 0, 0, 1, 32'hC,        32'h0,  0);
        exec_instr(32'hC,        0, 32'h0,        0, 0, 0, 1, 32'h10,       32'h0,  0);
        exec_instr(32'h10,       1, 32'h41,       1, 0, 0, 1, 32'h40,       32'h0,  0);
        exec_instr(32'h40,       1, 32'h10,       0, 0, 0, 1, 32'h10,       32'h0,  0);
        exec_instr(32'h10,       1, 32'h42,       0, 0, 0, 1, 32'h100,      32'h10, 1);
        check("misalign_one_cycle", {31'd0, misalign_trap}, 32'd1);
        exec_instr(32'h100,      1, 32'h20,       0, 0, 0, 1, 32'h20,       32'h10, 0);
        exec_instr(32'h20,       1, 32'h80,       0, 1, 0, 1, 32'h100,      32'h20, 0);
        exec_instr(32'h100,      1, 32'h30,       0, 0, 0, 1, 32'h30,       32'h20, 0);
        exec_instr(32'h30,       0, 32'h0,        0, 0, 2, 1, 32'h34,       32'h20, 0);
        exec_instr(32'h34,       1, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h20, 0);
        exec_instr(32'hFFFF_FFFC, 0, 32'h0,       0, 0, 0, 1, 32'h0,        32'h20, 0);
        exec_instr(32'h0,        1, 32'h200,      0, 0, 0, 0, 32'h200,      32'h20, 0);

        // Reset mid-FETCH with the request still pending.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, imem_valid}, 32'd0);
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_epc", epc, 32'h0);
        exp_q.delete();
        imem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(mk(32'h0, 32'h0, 1'b0));
        exec_instr(32'h0, 0, 32'h0, 0, 0, 0, 1, 32'h4, 32'h0, 0);
        wait_fetch();
        @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
